// File: rtl/muldiv_sequencer_pkg.sv
// ============================================================================
// Module : muldiv_sequencer_pkg
// Brief  : Shared CPU parameters: ALU control codes and mult/div state codes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package muldiv_sequencer_pkg;

  localparam logic [4:0] OPMULT  = 5'b11000;
  localparam logic [4:0] OPMULTU = 5'b11001;
  localparam logic [4:0] OPDIV   = 5'b11010;
  localparam logic [4:0] OPDIVU  = 5'b11011;
  localparam logic [4:0] OPMTHI  = 5'b11100;
  localparam logic [4:0] OPMTLO  = 5'b11101;

  localparam logic [5:0] ITER_LAST = 6'd31;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_signfix.sv
// ============================================================================
// Module : muldiv_signfix
// Brief  : Combinational two's-complement negate with select.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module muldiv_signfix #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_dout
);

  assign o_dout = i_neg ? (~i_din + {{(WIDTH-1){1'b0}}, 1'b1}) : i_din;

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module : muldiv_sequencer
// Brief  : Iterative 32x32 mult / restoring divide unit owning HI/LO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iStart,
  input  logic [4:0]  iOp,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic        iFlush,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oHI,
  output logic [31:0] oLO
);

  md_state_e   r_state;
  md_state_e   w_next;
  logic [5:0]  r_cnt;
  logic [31:0] r_opnd;
  logic [63:0] r_acc;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_is_div;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_signed;
  logic        w_accept;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_rem;
  logic [31:0] w_div_diff;
  logic        w_div_ge;
  logic [63:0] w_div_next;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  assign w_is_mul = (iOp == OPMULT) || (iOp == OPMULTU);
  assign w_is_div = (iOp == OPDIV)  || (iOp == OPDIVU);
  assign w_signed = (iOp == OPMULT) || (iOp == OPDIV);
  assign w_accept = (r_state == IDLE) && iStart;

  muldiv_signfix #(.WIDTH(32)) u_abs_a (.i_din(iA), .i_neg(w_signed & iA[31]), .o_dout(w_abs_a));
  muldiv_signfix #(.WIDTH(32)) u_abs_b (.i_din(iB), .i_neg(w_signed & iB[31]), .o_dout(w_abs_b));

  muldiv_signfix #(.WIDTH(64)) u_fix_prod (.i_din(r_acc),        .i_neg(r_neg_q), .o_dout(w_prod_fix));
  muldiv_signfix #(.WIDTH(32)) u_fix_quo  (.i_din(r_acc[31:0]),  .i_neg(r_neg_q), .o_dout(w_quo_fix));
  muldiv_signfix #(.WIDTH(32)) u_fix_rem  (.i_din(r_acc[63:32]), .i_neg(r_neg_r), .o_dout(w_rem_fix));

  // Multiply: acc low half holds the multiplier, shifted out LSB-first.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opnd : 32'd0)};
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}.
  assign w_div_rem  = r_acc[63:31];
  assign w_div_ge   = (w_div_rem >= {1'b0, r_opnd});
  assign w_div_diff = w_div_rem[31:0] - r_opnd;
  assign w_div_next = w_div_ge ? {w_div_diff, r_acc[30:0], 1'b1}
                               : {w_div_rem[31:0], r_acc[30:0], 1'b0};

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (iStart && w_is_mul)      w_next = MUL;
        else if (iStart && w_is_div) w_next = DIV;
      end
      MUL, DIV: begin
        if (iFlush)                  w_next = IDLE;
        else if (r_cnt == ITER_LAST) w_next = FIX;
      end
      FIX:     w_next = iFlush ? IDLE : DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_cnt    <= 6'd0;
      r_opnd   <= 32'd0;
      r_acc    <= 64'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      if (w_accept && w_is_mul) begin
        r_cnt    <= 6'd0;
        r_opnd   <= w_abs_a;
        r_acc    <= {32'd0, w_abs_b};
        r_neg_q  <= w_signed & (iA[31] ^ iB[31]);
        r_neg_r  <= 1'b0;
        r_is_div <= 1'b0;
      end else if (w_accept && w_is_div) begin
        r_cnt    <= 6'd0;
        r_opnd   <= w_abs_b;
        r_acc    <= {32'd0, w_abs_a};
        // Divide by zero keeps an all-ones quotient and the raw dividend.
        r_neg_q  <= w_signed & (iA[31] ^ iB[31]) & (iB != 32'd0);
        r_neg_r  <= w_signed & iA[31];
        r_is_div <= 1'b1;
      end else if (w_accept && (iOp == OPMTHI)) begin
        r_hi <= iA;
      end else if (w_accept && (iOp == OPMTLO)) begin
        r_lo <= iA;
      end

      if (r_state == MUL) begin
        r_acc <= w_mul_next;
        r_cnt <= r_cnt + 6'd1;
      end else if (r_state == DIV) begin
        r_acc <= w_div_next;
        r_cnt <= r_cnt + 6'd1;
      end

      if ((r_state == FIX) && !iFlush) begin
        if (r_is_div) begin
          r_hi <= w_rem_fix;
          r_lo <= w_quo_fix;
        end else begin
          r_hi <= w_prod_fix[63:32];
          r_lo <= w_prod_fix[31:0];
        end
      end
    end
  end

  assign oBusy = (r_state == MUL) || (r_state == DIV) || (r_state == FIX);
  assign oDone = (r_state == DONE);
  assign oHI   = r_hi;
  assign oLO   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module : tb_muldiv_sequencer
// Brief  : Directed scoreboard bench for muldiv_sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST_n;
  logic        iStart;
  logic [4:0]  iOp;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        iFlush;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oHI;
  logic [31:0] oLO;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];

  always #5 iCLK = ~iCLK;

  muldiv_sequencer dut (
    .iCLK  (iCLK),
    .iRST_n(iRST_n),
    .iStart(iStart),
    .iOp   (iOp),
    .iA    (iA),
    .iB    (iB),
    .iFlush(iFlush),
    .oBusy (oBusy),
    .oDone (oDone),
    .oHI   (oHI),
    .oLO   (oLO)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every oDone pulse must match the oldest queued HI:LO.
  always @(negedge iCLK) begin
    if (oDone !== 1'b0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got HI:LO=%h_%h expected no oDone", oHI, oLO);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({oHI, oLO} !== e) begin
          bad++;
          $display("FAIL done_result: got HI:LO=%h_%h expected %h", oHI, oLO, e);
        end
      end
    end
  end

  // kind: 0 none, 1 start OPMULT mid-op, 2 flush, 3 reset, 4 start in DONE
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit push, input logic [63:0] exp_hilo,
                        input int exp_cycles, input int kind, input int inj_cyc);
    int cnt;
    @(negedge iCLK);
    iStart = 1'b1; iOp = op; iA = a; iB = b;
    if (push) exp_q.push_back(exp_hilo);
    @(negedge iCLK);
    iStart = 1'b0;
    cnt = 0;
    while (oBusy && cnt < 100) begin
      cnt++;
      if (cnt == inj_cyc) begin
        if (kind == 1) begin
          iStart = 1'b1; iOp = OPMULT; iA = 32'd5; iB = 32'd5;
        end else if (kind == 2) begin
          iFlush = 1'b1;
        end else if (kind == 3) begin
          iRST_n = 1'b0;
          #1;
          check({name, "_rst_busy"}, {63'd0, oBusy}, 64'd0);
          check({name, "_rst_hilo"}, {oHI, oLO}, 64'd0);
        end
      end
      @(negedge iCLK);
      iStart = 1'b0;
      iFlush = 1'b0;
    end
    check({name, "_busy_cycles"}, 64'(cnt), 64'(exp_cycles));
    if (kind == 4) begin
      iStart = 1'b1; iOp = OPMULT; iA = 32'd9; iB = 32'd9;
      @(negedge iCLK);
      iStart = 1'b0;
      check({name, "_start_in_done_ignored"}, {63'd0, oBusy}, 64'd0);
    end else begin
      @(negedge iCLK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    iRST_n = 1'b0; iStart = 1'b0; iFlush = 1'b0; iOp = 5'd0; iA = 32'd0; iB = 32'd0;
    repeat (3) @(negedge iCLK);
    check("reset_hilo", {oHI, oLO}, 64'd0);
    check("reset_busy_done", {62'd0, oBusy, oDone}, 64'd0);
    iRST_n = 1'b1;

    run_op("mult_neg",   OPMULT,  32'hFFFFFFFE, 32'd3,        1, 64'hFFFFFFFF_FFFFFFFA, 33, 0, 0);
    run_op("multu_max",  OPMULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 64'hFFFFFFFE_00000001, 33, 0, 0);
    run_op("mult_mix",   OPMULT,  32'h7FFFFFFF, 32'h80000000, 1, 64'hC0000000_80000000, 33, 4, 0);
    run_op("div_neg",    OPDIV,   32'hFFFFFFF9, 32'd2,        1, 64'hFFFFFFFF_FFFFFFFD, 33, 0, 0);
    run_op("divu_zero",  OPDIVU,  32'd7,        32'd0,        1, 64'h00000007_FFFFFFFF, 33, 0, 0);
    run_op("div_zero_s", OPDIV,   32'hFFFFFFF0, 32'd0,        1, 64'hFFFFFFF0_FFFFFFFF, 33, 0, 0);
    run_op("div_ovf",    OPDIV,   32'h80000000, 32'hFFFFFFFF, 1, 64'h00000000_80000000, 33, 0, 0);
    run_op("div_mixed",  OPDIV,   32'd100,      32'hFFFFFFF9, 1, 64'h00000002_FFFFFFF2, 33, 0, 0);
    run_op("divu_mid",   OPDIVU,  32'd100,      32'd7,        1, 64'h00000002_0000000E, 33, 1, 5);

    // Move-to HI/LO from IDLE
    @(negedge iCLK);
    iStart = 1'b1; iOp = OPMTHI; iA = 32'h12345678;
    @(negedge iCLK);
    iStart = 1'b0;
    check("mthi_value", {32'd0, oHI}, 64'h12345678);
    check("mthi_busy", {62'd0, oBusy, oDone}, 64'd0);
    iStart = 1'b1; iOp = OPMTHI; iA = 32'hAAAA0000;
    @(negedge iCLK);
    iOp = OPMTLO; iA = 32'h0000BBBB;
    @(negedge iCLK);
    iStart = 1'b0;
    check("mt_preset", {oHI, oLO}, 64'hAAAA0000_0000BBBB);

    // Unassigned opcode is a no-op
    iStart = 1'b1; iOp = 5'd0; iA = 32'hDEADBEEF;
    @(negedge iCLK);
    iStart = 1'b0;
    check("noop_busy", {63'd0, oBusy}, 64'd0);
    check("noop_hilo", {oHI, oLO}, 64'hAAAA0000_0000BBBB);

    run_op("mult_flush", OPMULT, 32'd3, 32'd4, 0, 64'd0, 10, 2, 10);
    check("flush_mul_hilo", {oHI, oLO}, 64'hAAAA0000_0000BBBB);
    run_op("div_flush_fix", OPDIVU, 32'd50, 32'd5, 0, 64'd0, 33, 2, 33);
    check("flush_fix_hilo", {oHI, oLO}, 64'hAAAA0000_0000BBBB);
    repeat (3) @(negedge iCLK);

    run_op("div_reset", OPDIV, 32'd1000, 32'd3, 0, 64'd0, 20, 3, 20);
    check("after_reset_hilo", {oHI, oLO}, 64'd0);
    iRST_n = 1'b1;
    run_op("divu_post_rst", OPDIVU, 32'd100, 32'd7, 1, 64'h00000002_0000000E, 33, 0, 0);

    repeat (3) @(negedge iCLK);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port iCLK, input, 1: single clock; all state changes on rising edge.
REQ-002 SHALL have port iRST_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port iStart, input, 1: request strobe, sampled only in IDLE.
REQ-004 SHALL have port iOp, input, 5: ALU control code (OPMULT, OPMULTU, OPDIV, OPDIVU, OPMTHI, OPMTLO); other codes are no-ops.
REQ-005 SHALL have port iA, input, 32: rs operand (dividend/multiplicand/MT source).
REQ-006 SHALL have port iB, input, 32: rt operand (divisor/multiplier).
REQ-007 SHALL have port iFlush, input, 1: abort in-flight operation (exception/branch squash).
REQ-008 SHALL have port oBusy, output, 1: operation in flight; pipeline stalls MFHI/MFLO/mult/div while high.
REQ-009 SHALL have port oDone, output, 1: one-cycle pulse after HI/LO commit of a mult/div.
REQ-010 SHALL have ports oHI and oLO, output, 32 each: architectural HI/LO registers.

Function
REQ-011 SHALL implement states IDLE, MUL, DIV, FIX, DONE.
REQ-012 IDLE with iStart=1 and iOp in {OPMULT, OPMULTU} SHALL latch operand magnitudes (signed ops) or raw values (unsigned), record result signs, clear 6-bit iteration counter, and go to MUL.
REQ-013 IDLE with iStart=1 and iOp in {OPDIV, OPDIVU} SHALL do the same and go to DIV.
REQ-014 IDLE with iStart=1 and iOp=OPMTHI/OPMTLO SHALL write iA to HI/LO at that edge; state stays IDLE; oBusy and oDone stay 0.
REQ-015 iStart with any other iOp, or while not IDLE, SHALL be ignored.
REQ-016 MUL SHALL perform one shift-add step per cycle on a 64-bit accumulator; DIV one restoring-subtract step per cycle; each exactly 32 cycles, then go to FIX.
REQ-017 FIX SHALL apply sign correction (two's-complement negate product if signs differ; quotient negated if signs differ; remainder takes dividend sign) and write HI/LO at the FIX edge, then go to DONE.
REQ-018 DONE SHALL assert oDone for exactly one cycle and return to IDLE; iStart in DONE is ignored.
REQ-019 oBusy SHALL be 1 in MUL, DIV, FIX (33 cycles after accept edge) and 0 in IDLE and DONE.
REQ-020 Multiply: HI:LO = full 64-bit product (signed for OPMULT, unsigned for OPMULTU).
REQ-021 Divide: LO = quotient, HI = remainder, truncation toward zero.
REQ-022 Divide by zero SHALL run full latency and yield LO=0xFFFFFFFF, HI=iA (signed and unsigned).
REQ-023 OPDIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000.
REQ-024 iFlush=1 in MUL/DIV/FIX SHALL return to IDLE next edge with HI/LO unchanged and no oDone; iFlush in IDLE/DONE has no effect; iFlush and HI/LO commit at the same FIX edge: flush wins.
REQ-025 oHI/oLO SHALL change only on REQ-014 or REQ-017 commits.

Reset
REQ-026 iRST_n=0 SHALL immediately force IDLE, HI=0, LO=0, counter=0, oBusy=0, oDone=0, discarding any in-flight operation.
REQ-027 Reset release SHALL be sampled synchronously; first accept possible on the first edge with iRST_n=1.

Structure
REQ-028 The 5-bit ALU control codes (OPMULT, OPMULTU, OPDIV, OPDIVU, OPMTHI, OPMTLO) and state encodings SHALL reside in the shared CPU parameters package used by ALUControl; no local redefinition.
REQ-029 Sign capture/negation SHALL be a sub-module muldiv_signfix (combinational, 64-bit negate with select); sequencer and datapath iteration stay in muldiv_sequencer.

Verification
REQ-030 OPMULT A=0xFFFFFFFE (-2), B=3 -> oBusy 33 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFA, oDone one pulse.
REQ-031 OPMULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 OPDIV A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; OPDIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
REQ-033 OPMTHI A=0x12345678 in IDLE -> HI=0x12345678 next edge, oBusy never high; iStart OPMULT mid-DIV -> ignored, DIV result unaffected.
REQ-034 iFlush at MUL cycle 10 after HI/LO preset to 0xAAAA0000/0x0000BBBB -> IDLE next edge, HI/LO unchanged, no oDone.
REQ-035 iRST_n low at DIV cycle 20 -> immediate IDLE, HI=LO=0, oBusy=0; after release, new OPDIVU 100/7 -> LO=14, HI=2.
